// File: rtl/cheri_zeroize_eng.sv
// Memory zeroization engine: clears [base, top) with pipelined zero stores.
// Sweeps up or down, tracks outstanding LSU requests, supports abort.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   cmd_*               start command (base, top, direction), ready in IDLE
//   stop_i              software abort
//   unmasked_intr_i     interrupt abort (when ABORT_ON_INTR)
//   active_o, done_o    busy flag, one-cycle completion pulse
//   aborted_o, err_o    sticky status until next start
//   err_addr_o          byte address of first erroring store
//   ptr_o               committed frontier byte address
//   lsu_*               store request / grant / in-order response
module cheri_zeroize_eng #(
  parameter int WORD_BYTES      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter bit ABORT_ON_INTR   = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [31:0]             cmd_base_i,
  input  logic [31:0]             cmd_top_i,
  input  logic                    cmd_down_i,
  input  logic                    stop_i,
  input  logic                    unmasked_intr_i,
  output logic                    active_o,
  output logic                    done_o,
  output logic                    aborted_o,
  output logic                    err_o,
  output logic [31:0]             err_addr_o,
  output logic [31:0]             ptr_o,
  output logic                    lsu_req_o,
  input  logic                    lsu_gnt_i,
  output logic [31:0]             lsu_addr_o,
  output logic [8*WORD_BYTES:0]   lsu_wdata_o,
  output logic [WORD_BYTES-1:0]   lsu_be_o,
  input  logic                    lsu_resp_valid_i,
  input  logic                    lsu_resp_err_i
);

  localparam int OB = $clog2(WORD_BYTES);
  localparam int WI = 32 - OB;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_OC = CW'(MAX_OUTSTANDING);
  localparam logic [WI-1:0] ONE_W  = WI'(1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state_q;
  logic          down_q;
  logic [WI-1:0] iptr_q;
  logic [WI-1:0] cptr_q;
  logic [WI-1:0] rem_q;
  logic [WI-1:0] erra_q;
  logic [CW-1:0] oc_q;
  logic [CW-1:0] oc_d;
  logic          done_q;
  logic          aborted_q;
  logic          err_q;

  logic [WI-1:0] basew;
  logic [WI-1:0] topw;
  logic          nonempty;
  logic          stop_c;
  logic          req;
  logic          gnt_ok;
  logic          resp_ok;
  logic          last_gnt;
  logic [WI-1:0] iptr_nx;
  logic [WI-1:0] cptr_nx;
  logic [WI-1:0] resp_addr;
  logic          unused_lowbits;

  assign basew    = cmd_base_i[31:OB];
  assign topw     = cmd_top_i[31:OB];
  assign nonempty = topw > basew;

  // Low address bits are ignored: regions are word-aligned by truncation.
  assign unused_lowbits = ^{cmd_base_i[OB-1:0], cmd_top_i[OB-1:0]};

  assign stop_c = stop_i | (ABORT_ON_INTR & unmasked_intr_i);

  assign req = (state_q == ISSUE) &&
               (rem_q != '0) &&
               (oc_q < MAX_OC) &&
               !stop_c;

  assign gnt_ok   = req & lsu_gnt_i;
  assign resp_ok  = lsu_resp_valid_i &&
                    (state_q != IDLE) &&
                    (oc_q != '0);
  assign last_gnt = gnt_ok && (rem_q == ONE_W);

  assign iptr_nx = down_q ? iptr_q - ONE_W
                          : iptr_q + ONE_W;
  assign cptr_nx = down_q ? cptr_q - ONE_W
                          : cptr_q + ONE_W;

  // Down sweeps commit from top, so the word just
  // completed sits one below the committed pointer.
  assign resp_addr = down_q ? cptr_q - ONE_W : cptr_q;

  always_comb begin
    oc_d = oc_q;
    unique case ({gnt_ok, resp_ok})
      2'b10:   oc_d = oc_q + ONE_C;
      2'b01:   oc_d = oc_q - ONE_C;
      default: oc_d = oc_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      down_q    <= 1'b0;
      iptr_q    <= '0;
      cptr_q    <= '0;
      rem_q     <= '0;
      erra_q    <= '0;
      oc_q      <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      oc_q   <= oc_d;

      if (gnt_ok) begin
        iptr_q <= iptr_nx;
        rem_q  <= rem_q - ONE_W;
      end

      if (resp_ok) begin
        cptr_q <= cptr_nx;
        if (lsu_resp_err_i && !err_q) begin
          err_q  <= 1'b1;
          erra_q <= resp_addr;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
            erra_q    <= '0;
            if (nonempty) begin
              state_q <= ISSUE;
              down_q  <= cmd_down_i;
              iptr_q  <= cmd_down_i ? topw - ONE_W
                                    : basew;
              cptr_q  <= cmd_down_i ? topw : basew;
              rem_q   <= topw - basew;
              oc_q    <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (stop_c) begin
            state_q   <= DRAIN;
            aborted_q <= 1'b1;
          end else if (last_gnt) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (oc_d == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign active_o    = (state_q != IDLE);
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign err_o       = err_q;
  assign err_addr_o  = {erra_q, {OB{1'b0}}};
  assign ptr_o       = {cptr_q, {OB{1'b0}}};
  assign lsu_req_o   = req;
  assign lsu_addr_o  = {iptr_q, {OB{1'b0}}};
  assign lsu_wdata_o = '0;
  assign lsu_be_o    = '1;

endmodule
